board_clock_synth: RTL and testbench

- Four-channel digital clock synthesizer standing in for the board PLL (PLL / PLL1280 role) in the top-level board controller.
- Each channel is a 32-bit phase accumulator (NCO). Its MSB gives a square-wave output of frequency f_clk_cpu * INC / 2^32, with a programmable start phase.
- Provides a lock indicator so downstream logic can hold off until outputs are stable.

---
 rtl/board_clock_synth.sv | 81 ++++++++
 tb/tb_board_clock_synth.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_clock_synth.sv
// board_clock_synth: four-channel NCO clock synthesizer with lock flag.
// Each channel drives the registered MSB of a 32-bit phase accumulator.
module board_clock_synth #(
  parameter logic [31:0] INC0        = 32'h8000_0000,
  parameter logic [31:0] INC1        = 32'h8000_0000,
  parameter logic [31:0] INC2        = 32'h4000_0000,
  parameter logic [31:0] INC3        = 32'h2000_0000,
  parameter logic [31:0] PHASE0      = 32'h0000_0000,
  parameter logic [31:0] PHASE1      = 32'h4000_0000,
  parameter logic [31:0] PHASE2      = 32'h0000_0000,
  parameter logic [31:0] PHASE3      = 32'h0000_0000,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic [3:0] en,
  output logic       c0,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       locked
);

  localparam logic [31:0] INC [4] =
    '{INC0, INC1, INC2, INC3};
  localparam logic [31:0] PHASE [4] =
    '{PHASE0, PHASE1, PHASE2, PHASE3};
  localparam logic [15:0] LOCK_MAX =
    16'(LOCK_CYCLES);

  logic [31:0] acc [4];
  logic [3:0]  c_q;
  logic [15:0] lock_cnt;
  logic [15:0] lock_nxt;
  logic        locked_q;

  // Saturating lock counter next value.
  always_comb begin
    lock_nxt = lock_cnt;
    if (lock_cnt < LOCK_MAX)
      lock_nxt = lock_cnt + 16'd1;
  end

  // Accumulators advance when enabled and hold otherwise;
  // pins take the pre-update MSB, forced low when disabled.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        acc[i] <= PHASE[i];
      c_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (en[i]) begin
          acc[i] <= acc[i] + INC[i];
          c_q[i] <= acc[i][31];
        end else begin
          c_q[i] <= 1'b0;
        end
      end
    end
  end

  // Lock rises the edge the counter hits LOCK_MAX, then sticks.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      lock_cnt <= '0;
      locked_q <= 1'b0;
    end else begin
      lock_cnt <= lock_nxt;
      if (lock_nxt == LOCK_MAX)
        locked_q <= 1'b1;
    end
  end

  assign c0     = c_q[0];
  assign c1     = c_q[1];
  assign c2     = c_q[2];
  assign c3     = c_q[3];
  assign locked = locked_q;

endmodule

// File: tb/tb_board_clock_synth.sv
// tb_board_clock_synth: randomized bench for board_clock_synth.
// Expected pins come from closed-form phase = PHASE + k*INC.
module tb_board_clock_synth;

  logic       clk_cpu = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] en      = 4'h0;

  logic a_c0, a_c1, a_c2, a_c3, a_locked;
  logic b_c0, b_c1, b_c2, b_c3, b_locked;

  localparam int LOCK = 16;

  localparam logic [31:0] PH [4] =
    '{32'h0, 32'h4000_0000, 32'h0, 32'h0};
  localparam logic [31:0] IA [4] =
    '{32'h8000_0000, 32'h8000_0000,
      32'h4000_0000, 32'h2000_0000};
  localparam logic [31:0] IB [4] =
    '{32'h8000_0000, 32'h4000_0000,
      32'h4000_0000, 32'h3000_0000};

  board_clock_synth dut_a (
    .clk_cpu (clk_cpu),
    .reset   (reset),
    .en      (en),
    .c0      (a_c0),
    .c1      (a_c1),
    .c2      (a_c2),
    .c3      (a_c3),
    .locked  (a_locked)
  );

  board_clock_synth #(
    .INC1 (32'h4000_0000),
    .INC3 (32'h3000_0000)
  ) dut_b (
    .clk_cpu (clk_cpu),
    .reset   (reset),
    .en      (en),
    .c0      (b_c0),
    .c1      (b_c1),
    .c2      (b_c2),
    .c3      (b_c3),
    .locked  (b_locked)
  );

  always #5 clk_cpu = ~clk_cpu;

  logic [9:0] obs;
  assign obs = {a_c3, a_c2, a_c1, a_c0, a_locked,
                b_c3, b_c2, b_c1, b_c0, b_locked};

  int unsigned k [4];
  int          lock_n;
  logic [4:0]  exp_a, exp_b;
  logic [9:0]  expv;
  int          checks = 0;
  int          errors = 0;

  function automatic logic ph_msb(
    input logic [31:0] p,
    input logic [31:0] inc,
    input int unsigned n
  );
    logic [31:0] v;
    v = p + inc * n;
    return v[31];
  endfunction

  // Drive one cycle and advance the reference model.
  task automatic tick(input logic r,
                      input logic [3:0] e);
    @(negedge clk_cpu);
    reset = r;
    en    = e;
    @(posedge clk_cpu);
    if (r) begin
      for (int i = 0; i < 4; i++) k[i] = 0;
      lock_n = 0;
      exp_a  = '0;
      exp_b  = '0;
    end else begin
      lock_n++;
      for (int i = 0; i < 4; i++) begin
        if (e[i]) begin
          exp_a[i+1] = ph_msb(PH[i], IA[i], k[i]);
          exp_b[i+1] = ph_msb(PH[i], IB[i], k[i]);
          k[i]++;
        end else begin
          exp_a[i+1] = 1'b0;
          exp_b[i+1] = 1'b0;
        end
      end
      exp_a[0] = (lock_n >= LOCK);
      exp_b[0] = (lock_n >= LOCK);
    end
    expv = {exp_a, exp_b};
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 4'hF);
      checks++;
      if (obs !== 10'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b",
                 i, obs, 10'b0);
      end
    end
  endtask

  task automatic test_lock();
    tick(1'b1, 4'hF);
    for (int n = 1; n <= 40; n++) begin
      tick(1'b0, 4'hF);
      checks++;
      if (a_locked !== (n >= LOCK)) begin
        errors++;
        $display("FAIL lock_time n=%0d got=%b want=%b",
                 n, a_locked, (n >= LOCK));
      end
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL lock_wave n=%0d got=%b want=%b",
                 n, obs, expv);
      end
    end
    tick(1'b1, 4'hF);
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL mid_reset got=%b want=%b",
               obs, 10'b0);
    end
  endtask

  task automatic test_phase();
    logic [7:0] s1, s2;
    logic [7:0] w1, w2;
    logic       last_c1;
    w1 = 8'b0110_0110;
    w2 = 8'b0011_0011;
    tick(1'b1, 4'hF);
    for (int i = 7; i >= 0; i--) begin
      tick(1'b0, 4'hF);
      s1[i] = b_c1;
      s2[i] = b_c2;
    end
    checks++;
    if (s1 !== w1) begin
      errors++;
      $display("FAIL phase_c1 got=%b want=%b", s1, w1);
    end
    checks++;
    if (s2 !== w2) begin
      errors++;
      $display("FAIL phase_c2 got=%b want=%b", s2, w2);
    end
    for (int i = 0; i < 10000; i++) begin
      tick(1'b0, 4'hF);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL long_run cyc=%0d got=%b want=%b",
                 i, obs, expv);
      end
    end
    last_c1 = b_c1;
    tick(1'b0, 4'hF);
    checks++;
    if (b_c2 !== last_c1) begin
      errors++;
      $display("FAIL skew_10k got=%b want=%b",
               b_c2, last_c1);
    end
  endtask

  task automatic test_gating();
    tick(1'b1, 4'hF);
    for (int i = 0; i < 21; i++) begin
      if (i >= 6 && i < 9) tick(1'b0, 4'hB);
      else                 tick(1'b0, 4'hF);
      if (i >= 6 && i < 9) begin
        checks++;
        if ({a_c2, b_c2} !== 2'b00) begin
          errors++;
          $display("FAIL gate_low cyc=%0d got=%b want=00",
                   i, {a_c2, b_c2});
        end
      end
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL gate_wave cyc=%0d got=%b want=%b",
                 i, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [3:0] e;
    tick(1'b1, 4'hF);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      e = 4'($urandom);
      tick(r, e);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random cyc=%0d en=%h rst=%b got=%b want=%b",
                 i, e, r, obs, expv);
      end
    end
  endtask

  task automatic test_fraction();
    int   rises;
    logic prev;
    rises = 0;
    tick(1'b1, 4'hF);
    tick(1'b0, 4'hF);
    prev = b_c3;
    for (int i = 0; i < 4096; i++) begin
      tick(1'b0, 4'hF);
      if (!prev && b_c3) rises++;
      prev = b_c3;
    end
    checks++;
    if (rises !== 768) begin
      errors++;
      $display("FAIL frac_rises got=%0d want=768", rises);
    end
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL frac_end got=%b want=%b", obs, expv);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) k[i] = 0;
    lock_n = 0;
    exp_a  = '0;
    exp_b  = '0;
    expv   = '0;
    test_reset();
    test_lock();
    test_phase();
    test_gating();
    test_random();
    test_fraction();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
